// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the MIPS front end: opcodes, fetch FSM states, reset PC.
package fetch_stage_pkg;

   localparam logic [31:0] RESET_PC = 32'h0040_0000;

   // Opcodes (instr[31:26]) as decoded by Control
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HOLD   = 2'd1,
      SQUASH = 2'd2
   } fetchState_e;

endpackage

// File: rtl/fetch_stage_next_pc.sv
// Redirect decision for the instruction in ID: whether to take it and where to go.
module fetch_stage_next_pc
   import fetch_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  idValid,
   input  logic                  stall,
   input  logic                  jump,
   input  logic                  branchEq,
   input  logic                  branchNe,
   input  logic                  zero,
   input  logic [25:0]           jumpIndex,
   input  logic [DATA_WIDTH-1:0] idPcPlus4,
   input  logic [DATA_WIDTH-1:0] branchImm,
   output logic                  take,
   output logic [DATA_WIDTH-1:0] target
);

   // Stall always wins over a redirect; jumps keep the upper PC nibble.
   always_comb begin
      take = idValid & ~stall & (jump | (branchEq & zero) | (branchNe & ~zero));
      if (jump) begin
         target = DATA_WIDTH'({idPcPlus4[DATA_WIDTH-1 -: 4], jumpIndex, 2'b00});
      end else begin
         target = idPcPlus4 + (branchImm << 2);
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the imem req/ack handshake and the IF/ID register.
//
// Handshake: imem_req and imem_addr are registered. Once imem_req is high it stays high
// with imem_addr unchanged until a cycle where imem_ack is also high; that cycle carries
// the word on imem_rdata and completes the transfer. An ack while imem_req is low is ignored.
module fetch_stage #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = fetch_stage_pkg::RESET_PC
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_ack,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   input  logic                  stall,
   input  logic                  Jump,
   input  logic                  BranchEQ,
   input  logic                  BranchNE,
   input  logic                  Zero,
   input  logic [DATA_WIDTH-1:0] branch_imm,
   output logic [DATA_WIDTH-1:0] id_instr,
   output logic [DATA_WIDTH-1:0] id_pc_plus4,
   output logic                  id_valid,
   output logic [1:0]            dbgState
);
   import fetch_stage_pkg::*;

   localparam logic [DATA_WIDTH-1:0] WORD_STEP = DATA_WIDTH'(4);

   fetchState_e           state;
   logic [DATA_WIDTH-1:0] pc;
   logic                  reqReg;
   logic [DATA_WIDTH-1:0] idInstr;
   logic [DATA_WIDTH-1:0] idPcPlus4;
   logic                  idValid;
   logic [DATA_WIDTH-1:0] holdInstr;
   logic [DATA_WIDTH-1:0] holdPcPlus4;
   logic [DATA_WIDTH-1:0] squashTarget;
   logic                  ackSeen;
   logic [DATA_WIDTH-1:0] pcPlus4;
   logic                  take;
   logic [DATA_WIDTH-1:0] target;

   assign ackSeen = reqReg & imem_ack;
   assign pcPlus4 = pc + WORD_STEP;

   fetch_stage_next_pc #(.DATA_WIDTH(DATA_WIDTH)) uNextPc (
      .idValid   (idValid),
      .stall     (stall),
      .jump      (Jump),
      .branchEq  (BranchEQ),
      .branchNe  (BranchNE),
      .zero      (Zero),
      .jumpIndex (idInstr[25:0]),
      .idPcPlus4 (idPcPlus4),
      .branchImm (branch_imm),
      .take      (take),
      .target    (target)
   );

   // Fetch FSM: PC, request, IF/ID register, one-entry hold buffer and squash target.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= FETCH;
         pc           <= RESET_PC;
         reqReg       <= 1'b0;
         idInstr      <= '0;
         idPcPlus4    <= '0;
         idValid      <= 1'b0;
         holdInstr    <= '0;
         holdPcPlus4  <= '0;
         squashTarget <= '0;
      end else begin
         case (state)
            FETCH: begin
               reqReg <= 1'b1;
               if (take) begin
                  // Wrong-path word (if any) is dropped; ID becomes a bubble.
                  idInstr <= '0;
                  idValid <= 1'b0;
                  if (ackSeen || !reqReg) begin
                     pc <= target;
                  end else begin
                     // Request in flight: finish it at the old address first.
                     squashTarget <= target;
                     state        <= SQUASH;
                  end
               end else if (stall) begin
                  if (ackSeen) begin
                     holdInstr   <= imem_rdata;
                     holdPcPlus4 <= pcPlus4;
                     pc          <= pcPlus4;
                     reqReg      <= 1'b0;
                     state       <= HOLD;
                  end
               end else if (ackSeen) begin
                  idInstr   <= imem_rdata;
                  idPcPlus4 <= pcPlus4;
                  idValid   <= 1'b1;
                  pc        <= pcPlus4;
               end else begin
                  // Decode consumed its instruction and nothing arrived: bubble.
                  idInstr <= '0;
                  idValid <= 1'b0;
               end
            end
            HOLD: begin
               if (!stall) begin
                  state  <= FETCH;
                  reqReg <= 1'b1;
                  if (take) begin
                     idInstr <= '0;
                     idValid <= 1'b0;
                     pc      <= target;
                  end else begin
                     idInstr   <= holdInstr;
                     idPcPlus4 <= holdPcPlus4;
                     idValid   <= 1'b1;
                  end
               end
            end
            SQUASH: begin
               if (ackSeen) begin
                  pc    <= squashTarget;
                  state <= FETCH;
               end
            end
            default: begin
               state  <= FETCH;
               reqReg <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req    = reqReg;
   assign imem_addr   = pc;
   assign id_instr    = idInstr;
   assign id_pc_plus4 = idPcPlus4;
   assign id_valid    = idValid;
   assign dbgState    = state;

endmodule
